csr_counter_bank: RTL and testbench

CSR_COUNTER_BANK -- requirements
Module: csr_counter_bank

---
 rtl/csr_counter_bank.sv | 184 ++++++++++++++++++
 tb/tb_csr_counter_bank.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/csr_counter_bank.sv
// csr_counter_bank -- bank of NUM_CNT performance counters, CNT_W bits each,
// read and written over a 32-bit CSR path.
//   counter 0 : cycle count (every cycle)
//   counter 1 : retired instructions (retire_valid && !stall)
//   counter k : event k (evt[k] && !stall), k >= 2
// Ports
//   clk, rst          clock, async active-high reset
//   retire_valid      one instruction retired this cycle
//   stall             blocks instret and event counting
//   evt               per-counter event pulses (bits 0/1 ignored)
//   inh_we/inh_wdata  inhibit register load; bit k freezes counter k
//   wr_en/wr_sel/wr_hi/wr_data   32-bit half-word counter write
//   rd_en/rd_sel/rd_hi/rd_data   32-bit half-word counter read (combinational)
//   ovf_clr/ovf       sticky overflow flags, write-1-to-clear
// A low-word read snapshots the high word so that a following high read
// of the same counter returns a value consistent with the low word.

module csr_counter_lane #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             wr_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wr_data_i,
    input  logic             ovf_clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);
    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             ovf_set;
    logic             unused_wr;

    // Upper write bits are dropped when the high half is narrower than 32.
    assign unused_wr = ^wr_data_i;

    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        // A write owns the counter for this cycle: no increment, no overflow.
        if (wr_i) begin
            if (wr_hi_i) cnt_d[CNT_W-1:32] = wr_data_i[HI_W-1:0];
            else         cnt_d[31:0]       = wr_data_i;
        end else if (inc_i) begin
            cnt_d   = cnt_q + CNT_W'(1);
            ovf_set = &cnt_q;
        end
        // Set wins over clear when both land on the same edge.
        ovf_d = (ovf_q & ~ovf_clr_i) | ovf_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
endmodule

module csr_counter_bank #(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 64,
    localparam int SEL_W  = $clog2(NUM_CNT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               retire_valid,
    input  logic               stall,
    input  logic [NUM_CNT-1:0] evt,
    input  logic               inh_we,
    input  logic [NUM_CNT-1:0] inh_wdata,
    input  logic               wr_en,
    input  logic [SEL_W-1:0]   wr_sel,
    input  logic               wr_hi,
    input  logic [31:0]        wr_data,
    input  logic               rd_en,
    input  logic [SEL_W-1:0]   rd_sel,
    input  logic               rd_hi,
    output logic [31:0]        rd_data,
    input  logic [NUM_CNT-1:0] ovf_clr,
    output logic [NUM_CNT-1:0] ovf
);
    localparam int HI_W = CNT_W - 32;

    logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
    logic [NUM_CNT-1:0]            inc_en;
    logic [NUM_CNT-1:0]            wr_hit;
    logic [NUM_CNT-1:0]            inh_q;
    logic [HI_W-1:0]               hi_shadow_q, hi_shadow_d;
    logic [SEL_W-1:0]              shadow_sel_q, shadow_sel_d;
    logic                          shadow_vld_q, shadow_vld_d;
    logic [CNT_W-1:0]              sel_cnt;
    logic                          sel_ok;
    logic                          shadow_hit;
    logic                          unused_evt;

    assign unused_evt = ^evt[1:0];

    // Increment enables; the inhibit register gates every counter.
    assign inc_en[0] = ~inh_q[0];
    assign inc_en[1] = retire_valid & ~stall & ~inh_q[1];

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_lane
        if (k >= 2) begin : g_evt
            assign inc_en[k] = evt[k] & ~stall & ~inh_q[k];
        end
        assign wr_hit[k] = wr_en && (wr_sel == SEL_W'(k));

        csr_counter_lane #(.CNT_W(CNT_W)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .inc_i    (inc_en[k]),
            .wr_i     (wr_hit[k]),
            .wr_hi_i  (wr_hi),
            .wr_data_i(wr_data),
            .ovf_clr_i(ovf_clr[k]),
            .cnt_o    (cnt[k]),
            .ovf_o    (ovf[k])
        );
    end

    // Read mux; an index with no matching counter yields sel_ok = 0.
    always_comb begin
        sel_cnt = '0;
        sel_ok  = 1'b0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (rd_sel == SEL_W'(k)) begin
                sel_cnt = cnt[k];
                sel_ok  = 1'b1;
            end
        end
    end

    assign shadow_hit = shadow_vld_q && (rd_sel == shadow_sel_q);

    always_comb begin
        rd_data = '0;
        if (!rst && rd_en && sel_ok) begin
            if (rd_hi) rd_data = 32'(shadow_hit ? hi_shadow_q : sel_cnt[CNT_W-1:32]);
            else       rd_data = sel_cnt[31:0];
        end
    end

    // Snapshot: low read captures the high word; matching high read consumes it.
    // A write to the snapshotted counter invalidates it, including one that
    // coincides with the capturing low read.
    always_comb begin
        hi_shadow_d  = hi_shadow_q;
        shadow_sel_d = shadow_sel_q;
        shadow_vld_d = shadow_vld_q;
        if (rd_en && !rd_hi) begin
            hi_shadow_d  = sel_cnt[CNT_W-1:32];
            shadow_sel_d = rd_sel;
            shadow_vld_d = 1'b1;
        end else if (rd_en && rd_hi && shadow_hit) begin
            shadow_vld_d = 1'b0;
        end
        if (wr_en && (wr_sel == shadow_sel_d)) shadow_vld_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inh_q        <= '0;
            hi_shadow_q  <= '0;
            shadow_sel_q <= '0;
            shadow_vld_q <= 1'b0;
        end else begin
            if (inh_we) inh_q <= inh_wdata;
            hi_shadow_q  <= hi_shadow_d;
            shadow_sel_q <= shadow_sel_d;
            shadow_vld_q <= shadow_vld_d;
        end
    end
endmodule

// File: tb/tb_csr_counter_bank.sv
module tb_csr_counter_bank;
    logic        clk, rst;
    logic        retire_valid, stall;
    logic [3:0]  evt, inh_wdata, ovf_clr, ovf;
    logic        inh_we, wr_en, wr_hi, rd_en, rd_hi;
    logic [1:0]  wr_sel, rd_sel;
    logic [31:0] wr_data, rd_data;

    int total = 0;
    int bad   = 0;

    csr_counter_bank #(.NUM_CNT(4), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .stall(stall),
        .evt(evt), .inh_we(inh_we), .inh_wdata(inh_wdata),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_hi(wr_hi), .wr_data(wr_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_hi(rd_hi), .rd_data(rd_data),
        .ovf_clr(ovf_clr), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs applied here take effect on the next edge; returns 1ns after it.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Non-latching read: rd_en drops again well before the next edge.
    task automatic rchk(input string tag, input logic [1:0] sel, input logic hi,
                        input logic [31:0] exp);
        rd_en = 1'b1; rd_sel = sel; rd_hi = hi;
        #1;
        chk(tag, rd_data, exp);
        rd_en = 1'b0; rd_hi = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic hi, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_hi = hi; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; retire_valid = 0; stall = 0; evt = 0; inh_we = 0; inh_wdata = 0;
        wr_en = 0; wr_sel = 0; wr_hi = 0; wr_data = 0; rd_en = 1; rd_sel = 0;
        rd_hi = 0; ovf_clr = 0;
        #1;
        chk("rd_in_reset", rd_data, 32'h0);
        step(2);
        chk("ovf_reset", {28'h0, ovf}, 32'h0);
        rd_en = 1'b0;
        rst = 1'b0;

        // idle 10 cycles
        step(10);
        rchk("cycle_after10", 2'd0, 1'b0, 32'd10);
        rchk("instret_idle", 2'd1, 1'b0, 32'd0);
        rchk("cycle_hi_idle", 2'd0, 1'b1, 32'd0);

        // wrap of instret
        wr(2'd1, 1'b0, 32'hFFFF_FFFF);
        wr(2'd1, 1'b1, 32'hFFFF_FFFF);
        rchk("c1_lo_ones", 2'd1, 1'b0, 32'hFFFF_FFFF);
        rchk("c1_hi_ones", 2'd1, 1'b1, 32'hFFFF_FFFF);
        chk("ovf_no_wr_set", {28'h0, ovf}, 32'h0);
        retire_valid = 1'b1; step(); retire_valid = 1'b0;
        rchk("c1_wrap_lo", 2'd1, 1'b0, 32'h0);
        rchk("c1_wrap_hi", 2'd1, 1'b1, 32'h0);
        chk("ovf_set", {28'h0, ovf}, 32'h2);
        step(2);
        chk("ovf_sticky", {28'h0, ovf}, 32'h2);
        ovf_clr = 4'b0010; step(); ovf_clr = 4'b0000;
        chk("ovf_clr", {28'h0, ovf}, 32'h0);
        // set and clear on the same edge: set wins
        wr(2'd1, 1'b0, 32'hFFFF_FFFF);
        wr(2'd1, 1'b1, 32'hFFFF_FFFF);
        retire_valid = 1'b1; ovf_clr = 4'b0010; step();
        retire_valid = 1'b0; ovf_clr = 4'b0000;
        chk("ovf_set_wins", {28'h0, ovf}, 32'h2);
        ovf_clr = 4'b0010; step(); ovf_clr = 4'b0000;
        chk("ovf_clr2", {28'h0, ovf}, 32'h0);

        // snapshot on cycle counter: 0x0_FFFFFFFF
        wr(2'd0, 1'b1, 32'h0);
        wr(2'd0, 1'b0, 32'hFFFF_FFFF);
        rd_en = 1'b1; rd_sel = 2'd0; rd_hi = 1'b0;
        #1;
        chk("snap_lo", rd_data, 32'hFFFF_FFFF);
        step();                     // counter -> 0x1_00000000, shadow = 0
        rd_hi = 1'b1;
        #1;
        chk("snap_hi_shadow", rd_data, 32'h0);
        step();                     // shadow consumed, counter 0x1_00000001
        chk("snap_hi_live", rd_data, 32'h1);
        rd_en = 1'b0; rd_hi = 1'b0;
        rchk("c0_lo_after_snap", 2'd0, 1'b0, 32'h1);

        // inhibit counter 0 (load edge still counts: lo -> 2)
        inh_we = 1'b1; inh_wdata = 4'b0001; step(); inh_we = 1'b0;
        retire_valid = 1'b1; step(3); retire_valid = 1'b0;
        rchk("c0_inhibited_lo", 2'd0, 1'b0, 32'd2);
        rchk("c0_inhibited_hi", 2'd0, 1'b1, 32'd1);
        rchk("c1_counts", 2'd1, 1'b0, 32'd3);
        inh_we = 1'b1; inh_wdata = 4'b0000; step(); inh_we = 1'b0;

        // stall freezes 1..3 but not 0
        stall = 1'b1; retire_valid = 1'b1; evt = 4'b1100; step(2);
        stall = 1'b0; retire_valid = 1'b0; evt = 4'b0000;
        rchk("c0_stall", 2'd0, 1'b0, 32'd4);
        rchk("c1_stall", 2'd1, 1'b0, 32'd3);
        rchk("c2_stall", 2'd2, 1'b0, 32'd0);
        rchk("c3_stall", 2'd3, 1'b0, 32'd0);
        evt = 4'b1100; step();
        evt = 4'b0011; step();      // bits 0/1 ignored
        evt = 4'b0000;
        rchk("c2_evt", 2'd2, 1'b0, 32'd1);
        rchk("c3_evt", 2'd3, 1'b0, 32'd1);
        rchk("c1_evt_ign", 2'd1, 1'b0, 32'd3);
        rchk("c0_run", 2'd0, 1'b0, 32'd6);

        // collision: write wins over event increment
        evt = 4'b0100;
        wr(2'd2, 1'b0, 32'h1234_5678);
        evt = 4'b0000;
        rchk("collide_lo", 2'd2, 1'b0, 32'h1234_5678);
        rchk("collide_hi", 2'd2, 1'b1, 32'h0);
        rd_sel = 2'd2; rd_en = 1'b0;
        #1;
        chk("rd_en_off", rd_data, 32'h0);

        // overflow on an event counter, then async reset mid-cycle
        wr(2'd3, 1'b0, 32'hFFFF_FFFF);
        wr(2'd3, 1'b1, 32'hFFFF_FFFF);
        evt = 4'b1000; step(); evt = 4'b0000;
        chk("ovf3_set", {28'h0, ovf}, 32'h8);
        rchk("c3_wrap", 2'd3, 1'b0, 32'h0);
        rst = 1'b1; rd_en = 1'b1; rd_sel = 2'd2;
        #1;
        chk("rd_async_rst", rd_data, 32'h0);
        rst = 1'b0; rd_en = 1'b0;
        chk("ovf_async_rst", {28'h0, ovf}, 32'h0);
        rchk("c2_async_rst", 2'd2, 1'b0, 32'h0);
        rchk("c0_async_rst", 2'd0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
